// File: rtl/mem_port_pkg.sv
// Shared types for the memory-port responder: FSM states, request kinds, wait-counter width.
package mem_port_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        KindFetch,
        KindLoad,
        KindStore
    } kind_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that saturates at zero; paces the ACCESS phase of mem_port_ctrl.
module mem_wait_counter
    import mem_port_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic [WAIT_W-1:0] cnt_o,
    output logic              zero_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-side responder for fetch/load/store requests with configurable RAM wait states.
// Define MEM_PORT_ALIGN_CHECK_EN to reject misaligned addresses with rsp_err instead of accessing RAM.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_ifetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              IRWrite,
    output logic              MDRWrite,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [WAIT_W-1:0] WaitLoad = WAIT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [ADDR_W-1:2]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                accept;
    logic                misaligned;
    logic                err;
    logic [WAIT_W-1:0]   cnt;
    logic                cnt_zero;

`ifdef MEM_PORT_ALIGN_CHECK_EN
    logic err_q, err_d;

    assign misaligned = (req_addr[1:0] != 2'b00);
    assign err_d      = accept ? misaligned : err_q;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    // Byte offset is dropped; the access goes to the enclosing word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign misaligned      = 1'b0;
    assign err             = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    addr_d  = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    kind_d  = req_we ? KindStore : (req_ifetch ? KindFetch : KindLoad);
                    state_d = misaligned ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (cnt_zero) begin
                    state_d = (kind_q == KindStore) ? StDone : StCapture;
                end
            end
            StCapture: begin
                rdata_d = mem_rdata;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            kind_q  <= KindFetch;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mem_wait_counter u_wait_counter (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (accept),
        .load_val_i (WaitLoad),
        .dec_i      (mem_en),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    assign req_ready = (state_q == StIdle);
    assign mem_en    = (state_q == StAccess);
    // Counter still holds its load value only in the first ACCESS cycle.
    assign mem_we    = mem_en && (kind_q == KindStore) && (cnt == WaitLoad);
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rdata_q;
    assign rsp_err   = rsp_valid && err;
    assign IRWrite   = rsp_valid && !err && (kind_q == KindFetch);
    assign MDRWrite  = rsp_valid && !err && (kind_q == KindLoad);

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Memory-side responder of the multi-cycle CPU's fetch/load/store interface.
- Accepts one request at a time from the control unit. Drives a unified synchronous RAM with configurable wait states.
- Returns read data with a one-cycle IRWrite strobe (instruction fetch) or MDR-write strobe (data load).
- Sits between the control FSM/datapath and memory. It is the producer of MemData and IRWrite for the instruction register.

Parameters:
- WAIT_CYCLES, 0, extra ACCESS cycles beyond the first (models slow memory); legal range 0..15.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_we  in  1  1=store, 0=read
- req_ifetch  in  1  read is an instruction fetch (ignored when req_we=1)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  registered read data; holds last read value
- rsp_err  out  1  misaligned access, valid with rsp_valid
- IRWrite  out  1  one-cycle pulse with rsp_valid on a fetch read
- MDRWrite  out  1  one-cycle pulse with rsp_valid on a data read
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word-aligned address (bits [1:0] forced 0)
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after the last mem_en cycle

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rsp_valid, rsp_err, IRWrite, MDRWrite, mem_en and mem_we go to 0.
  - rsp_data, mem_addr and mem_wdata go to 0x0000_0000.
  - Reset mid-access aborts the access: no response, no strobe. A store whose mem_we was already sampled by the RAM is not undone.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch addr, wdata, we and ifetch; load the wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr=latched address every cycle.
  - mem_we=1 only in the first ACCESS cycle of a store.
  - Counter decrements each cycle. At counter==0: a read goes to CAPTURE, a store goes to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- CAPTURE: rsp_data <= mem_rdata; go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - IRWrite=1 if read and ifetch; MDRWrite=1 if read and not ifetch; a store pulses neither.
  - Go to IDLE.
- Latency: request accepted at edge T.
  - Read: DONE at cycle T+3+WAIT_CYCLES.
  - Store: DONE at cycle T+2+WAIT_CYCLES.
- req_valid outside IDLE is ignored. The requester must hold the request until req_ready is high. No queuing.
- rsp_data changes only in CAPTURE. Stores leave rsp_data unchanged.
- A new request may be accepted in the cycle after DONE (back-to-back throughput: 4+W cycles per read).
- Counter is 4 bits; WAIT_CYCLES=0 never decrements below 0.

Optional Feature:
- Macro MEM_PORT_ALIGN_CHECK_EN.
- Defined:
  - If req_addr[1:0]!=0 at accept, go straight to DONE with rsp_err=1.
  - No mem_en, no mem_we, no IRWrite/MDRWrite; rsp_data unchanged.
- Undefined: rsp_err tied 0; addr[1:0] ignored and the access proceeds to the aligned word.

Decomposition:
- Package mem_port_pkg: state enum (IDLE, ACCESS, CAPTURE, DONE), WAIT_W=4 constant, request-kind encoding (FETCH, LOAD, STORE).
- One natural sub-module: mem_wait_counter, a loadable down-counter with a zero flag used by ACCESS.

Test Plan:
- WAIT_CYCLES=0, fetch at addr 0x0000_0010, RAM word 0x8C01_0004 -> rsp_valid, IRWrite and rsp_data=0x8C01_0004 at T+3; MDRWrite stays 0.
- WAIT_CYCLES=3, load at 0x0000_0100, RAM word 0xDEAD_BEEF -> mem_en high 4 cycles; rsp_valid and MDRWrite at T+6 with data 0xDEAD_BEEF; req_ready low T+1..T+6.
- Store 0x1234_5678 to 0x0000_0040, then load from 0x40 -> mem_we pulses exactly once; store done pulses neither strobe; load returns 0x1234_5678; rsp_data unchanged after the store.
- req_valid held high during ACCESS with different address 0x80 -> ignored; the original access completes; 0x80 is accepted only after return to IDLE.
- rst_n asserted in the second ACCESS cycle (WAIT_CYCLES=2) -> all outputs 0 immediately; no rsp_valid or IRWrite after release; req_ready=1 on the first edge after release.
- With MEM_PORT_ALIGN_CHECK_EN, load at 0x0000_0013 -> rsp_valid and rsp_err at T+1, mem_en never asserted, no strobes. Without the macro -> word 0x10 is read and rsp_err=0.
